// File: rtl/fft8_mag_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : fft8_mag_stream_if
// Purpose  : Sample-in / magnitude-out stream bundle for fft8_mag_stream.
// Revision : 1.0
// ============================================================================
interface fft8_mag_stream_if #(
    parameter int DATA_W = 8,
    parameter int MAG_W  = 16
) ();
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [2:0]               out_bin;
    logic [MAG_W-1:0]         out_mag;
    logic                     out_last;
    logic [1:0]               out_level;

    // The engine is the slave of this bus: it sinks samples and sources bins.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bin, out_mag, out_last, out_level
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bin, out_mag, out_last, out_level
    );
endinterface
`default_nettype wire

// File: rtl/fft8_mag_stream.sv
`default_nettype none
// ============================================================================
// Module   : fft8_mag_stream
// Purpose  : 8-point real-input DFT magnitude engine. Loads 8 samples, then
//            computes saturated |X[k]|^2 per bin with one complex MAC.
//            Optional macro LEVEL_OUT_EN adds a registered 2-bit level code.
// Revision : 1.0
// ============================================================================
module fft8_mag_stream #(
    parameter int DATA_W   = 8,
    parameter int MAG_W    = 16,
    parameter int LEVEL_T1 = 256,
    parameter int LEVEL_T2 = 4096,
    parameter int LEVEL_T3 = 16384
) (
    input wire               clk,
    input wire               rst_n,
    input wire               ena,
    fft8_mag_stream_if.slave bus
);
    localparam int c_ACC_W  = DATA_W + 11;
    localparam int c_MAGF_W = 2 * c_ACC_W;

    if (DATA_W < 4 || DATA_W > 12 || LEVEL_T1 > LEVEL_T2 || LEVEL_T2 > LEVEL_T3) begin : g_param_check
        $error("fft8_mag_stream: DATA_W must be 4..12 and thresholds ascending");
    end

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_MAC  = 2'd1,
        S_MAG  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                      r_in_ready;
    logic [2:0]                r_cnt;
    logic [2:0]                r_k;
    logic [2:0]                r_n;
    logic signed [DATA_W-1:0]  r_buf [8];
    logic signed [c_ACC_W-1:0] r_acc_re;
    logic signed [c_ACC_W-1:0] r_acc_im;
    logic                      r_out_valid;
    logic [2:0]                r_out_bin;
    logic [MAG_W-1:0]          r_out_mag;
    logic                      r_out_last;

    logic signed [DATA_W-1:0]  w_in_data;
    logic                      w_in_fire;
    logic                      w_out_fire;
    logic [2:0]                w_m;
    logic signed [DATA_W-1:0]  w_x;
    logic signed [8:0]         w_cos;
    logic signed [8:0]         w_sin;
    logic signed [c_ACC_W-1:0] w_prod_re;
    logic signed [c_ACC_W-1:0] w_prod_im;
    logic signed [c_ACC_W-1:0] w_re_sh;
    logic signed [c_ACC_W-1:0] w_im_sh;
    logic [c_MAGF_W-1:0]       w_re_sq;
    logic [c_MAGF_W-1:0]       w_im_sq;
    logic [c_MAGF_W-1:0]       w_mag;
    logic [MAG_W-1:0]          w_mag_sat;

    // Q1.7 cosine table; sine is the same table delayed by a quarter turn.
    function automatic logic signed [8:0] f_cos(input logic [2:0] m);
        case (m)
            3'd0:    f_cos = 9'sd128;
            3'd1:    f_cos = 9'sd91;
            3'd2:    f_cos = 9'sd0;
            3'd3:    f_cos = -9'sd91;
            3'd4:    f_cos = -9'sd128;
            3'd5:    f_cos = -9'sd91;
            3'd6:    f_cos = 9'sd0;
            default: f_cos = 9'sd91;
        endcase
    endfunction

    assign w_in_data  = bus.in_data;
    assign w_in_fire  = (r_state == S_LOAD) & bus.in_valid & r_in_ready & ena;
    assign w_out_fire = (r_state == S_OUT) & r_out_valid & bus.out_ready & ena;

    // k*n mod 8 falls out of keeping only the low three product bits.
    assign w_m       = r_k * r_n;
    assign w_x       = r_buf[r_n];
    assign w_cos     = f_cos(w_m);
    assign w_sin     = f_cos(w_m - 3'd2);
    assign w_prod_re = c_ACC_W'(w_x) * c_ACC_W'(w_cos);
    assign w_prod_im = c_ACC_W'(w_x) * c_ACC_W'(w_sin);

    assign w_re_sh = r_acc_re >>> 7;
    assign w_im_sh = r_acc_im >>> 7;
    assign w_re_sq = c_MAGF_W'(w_re_sh) * c_MAGF_W'(w_re_sh);
    assign w_im_sq = c_MAGF_W'(w_im_sh) * c_MAGF_W'(w_im_sh);
    assign w_mag   = w_re_sq + w_im_sq;

    if (c_MAGF_W > MAG_W) begin : g_sat
        assign w_mag_sat = (|w_mag[c_MAGF_W-1:MAG_W]) ? {MAG_W{1'b1}} : w_mag[MAG_W-1:0];
    end else begin : g_nosat
        assign w_mag_sat = MAG_W'(w_mag);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else if (ena) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:  if (w_in_fire && r_cnt == 3'd7) w_next = S_MAC;
            S_MAC:   if (ena && r_n == 3'd7) w_next = S_MAG;
            S_MAG:   if (ena) w_next = S_OUT;
            S_OUT:   if (w_out_fire) w_next = (r_k == 3'd7) ? S_LOAD : S_MAC;
            default: w_next = S_LOAD;
        endcase
    end

    // in_ready is registered so it is low throughout reset and tracks the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
        end else if (ena) begin
            r_in_ready <= (w_next == S_LOAD);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_k         <= '0;
            r_n         <= '0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_out_valid <= 1'b0;
            r_out_bin   <= '0;
            r_out_mag   <= '0;
            r_out_last  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_buf[i] <= '0;
            end
        end else if (ena) begin
            case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_buf[r_cnt] <= w_in_data;
                        r_cnt        <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_acc_re <= '0;
                            r_acc_im <= '0;
                            r_k      <= '0;
                            r_n      <= '0;
                        end
                    end
                end
                S_MAC: begin
                    r_acc_re <= r_acc_re + w_prod_re;
                    r_acc_im <= r_acc_im - w_prod_im;
                    r_n      <= r_n + 3'd1;
                end
                S_MAG: begin
                    r_out_valid <= 1'b1;
                    r_out_bin   <= r_k;
                    r_out_mag   <= w_mag_sat;
                    r_out_last  <= (r_k == 3'd7);
                end
                S_OUT: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_n         <= '0;
                        r_acc_re    <= '0;
                        r_acc_im    <= '0;
                        if (r_k == 3'd7) begin
                            r_cnt <= '0;
                        end else begin
                            r_k <= r_k + 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LEVEL_OUT_EN
    localparam logic [c_MAGF_W-1:0] c_T1 = c_MAGF_W'(LEVEL_T1);
    localparam logic [c_MAGF_W-1:0] c_T2 = c_MAGF_W'(LEVEL_T2);
    localparam logic [c_MAGF_W-1:0] c_T3 = c_MAGF_W'(LEVEL_T3);

    logic [1:0] r_out_level;
    logic [1:0] w_level;

    // Quantised from the unsaturated magnitude so level 3 survives clipping.
    always_comb begin
        w_level = 2'd0;
        if (w_mag >= c_T3) begin
            w_level = 2'd3;
        end else if (w_mag >= c_T2) begin
            w_level = 2'd2;
        end else if (w_mag >= c_T1) begin
            w_level = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_level <= 2'd0;
        end else if (ena && r_state == S_MAG) begin
            r_out_level <= w_level;
        end
    end

    assign bus.out_level = r_out_level;
`else
    assign bus.out_level = 2'b00;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_bin   = r_out_bin;
    assign bus.out_mag   = r_out_mag;
    assign bus.out_last  = r_out_last;

endmodule
`default_nettype wire
